// File: rtl/gpio_input_debouncer.sv
// Synchronise, tick-sample and per-bit debounce raw board inputs for the GPIO block.
// Optional DEBOUNCE_EDGE_EN adds per-bit rise/fall strobes aligned with db_change.
module gpio_input_debouncer #(
  parameter int WIDTH      = 16,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
`ifdef DEBOUNCE_EDGE_EN
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
`endif
  output logic             db_change
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] db_nxt;

  // Stage: two-flop synchroniser and sample-tick prescaler
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s1    <= '0;
      s2    <= '0;
      presc <= '0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Stage: per-channel run counters; any matching sample restarts the run
  always_comb begin
    db_nxt = db_out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (s2[i] == db_out[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          db_nxt[i]  = s2[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Stage: debounced outputs and change strobes
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      db_out    <= '0;
      db_change <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      db_out    <= db_nxt;
      db_change <= |(db_nxt ^ db_out);
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= db_nxt & ~db_out;
      fall_pulse <= ~db_nxt & db_out;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Self-checking bench for gpio_input_debouncer: vector table, corner sequences and
// randomized traffic against a sample-history reference model.
module tb_gpio_input_debouncer;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int N  = 3;
  localparam logic [7:0] MASK = 8'((1 << N) - 1);

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [W-1:0]  raw_in;
  logic [W-1:0]  db_out;
  logic          db_change;
`ifdef DEBOUNCE_EDGE_EN
  logic [W-1:0]  rise_pulse;
  logic [W-1:0]  fall_pulse;
`endif

  gpio_input_debouncer #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(N)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .raw_in    (raw_in),
    .db_out    (db_out),
`ifdef DEBOUNCE_EDGE_EN
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
`endif
    .db_change (db_change)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;
  int chg_seen = 0;

  // Reference model: raw delayed two cycles, tick every TD cycles, and a bit
  // flips once the last N tick samples since its previous flip all disagree.
  logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
  logic         m_chg;
  logic         m_tick;
  int           m_cyc;
  logic [7:0]   m_hist  [W];
  int           m_since [W];

  task automatic model_update(input logic [W-1:0] r, input logic rn);
    logic [W-1:0] nd;
    logic [7:0]   want;
    if (!rn) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      m_chg = 1'b0; m_tick = 1'b0; m_cyc = 0;
      for (int i = 0; i < W; i++) begin
        m_hist[i] = '0;
        m_since[i] = 0;
      end
    end else begin
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      nd = m_db;
      if (m_tick) begin
        for (int i = 0; i < W; i++) begin
          m_hist[i] = {m_hist[i][6:0], m_s2[i]};
          m_since[i]++;
          want = m_db[i] ? 8'h00 : MASK;
          if (m_since[i] >= N && (m_hist[i] & MASK) == want) begin
            nd[i] = ~m_db[i];
            m_since[i] = 0;
          end
        end
      end
      m_chg  = (nd != m_db);
      m_rise = nd & ~m_db;
      m_fall = ~nd & m_db;
      m_db   = nd;
      m_s2   = m_s1;
      m_s1   = r;
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [W-1:0] r, input logic rn);
    raw_in  = r;
    HRESETn = rn;
    @(posedge HCLK);
    model_update(r, rn);
    #1;
    chk("model_db_out", db_out, m_db);
    chk("model_db_change", {15'b0, db_change}, {15'b0, m_chg});
`ifdef DEBOUNCE_EDGE_EN
    chk("model_rise_pulse", rise_pulse, m_rise);
    chk("model_fall_pulse", fall_pulse, m_fall);
`endif
    if (db_change) chg_seen++;
  endtask

  // Holds v so that exactly the next tick samples it; call right after a tick.
  task automatic run_tick(input logic [W-1:0] v);
    repeat (TD) step(v, 1'b1);
  endtask

  task automatic align();
    for (int k = 0; k < TD && !m_tick; k++) step(raw_in, 1'b1);
    n_cmp++;
    if (!m_tick) begin
      n_err++;
      $display("FAIL align: no tick within %0d cycles", TD);
    end
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic         rstn;
    logic [W-1:0] db;
    logic         chg;
    logic [W-1:0] rise;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [W-1:0] snap;
    logic [W-1:0] r;
    logic         rn;

    HRESETn = 1'b0;
    raw_in  = 16'hFFFF;

    // Reset for 3 cycles, release with raw=0, then a clean step on bit 0.
    // Rows are edges; edge 3 after release is the first tick, so the third
    // mismatching tick is edge 11 after release (row 14).
    for (int k = 0; k < 16; k++) begin
      tbl[k].raw  = (k < 3) ? 16'hFFFF : (k == 3) ? 16'h0000 : 16'h0001;
      tbl[k].rstn = (k >= 3);
      tbl[k].db   = (k >= 14) ? 16'h0001 : 16'h0000;
      tbl[k].chg  = (k == 14);
      tbl[k].rise = (k == 14) ? 16'h0001 : 16'h0000;
    end
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].raw, tbl[k].rstn);
      chk($sformatf("tbl_db_out[%0d]", k), db_out, tbl[k].db);
      chk($sformatf("tbl_db_change[%0d]", k), {15'b0, db_change}, {15'b0, tbl[k].chg});
`ifdef DEBOUNCE_EDGE_EN
      chk($sformatf("tbl_rise[%0d]", k), rise_pulse, tbl[k].rise);
`endif
    end

    // Bounce: bring bit 0 back to 0, then samples 1,1,0,1,1,1.
    align();
    run_tick(16'h0000);
    run_tick(16'h0000);
    chk("bounce_pre_hold", db_out, 16'h0001);
    run_tick(16'h0000);
    chk("bounce_pre_clear", db_out, 16'h0000);
    run_tick(16'h0001); chk("bounce_t1", db_out, 16'h0000);
    run_tick(16'h0001); chk("bounce_t2", db_out, 16'h0000);
    run_tick(16'h0000); chk("bounce_t3", db_out, 16'h0000);
    run_tick(16'h0001); chk("bounce_t4", db_out, 16'h0000);
    run_tick(16'h0001); chk("bounce_t5", db_out, 16'h0000);
    run_tick(16'h0001); chk("bounce_t6", db_out, 16'h0001);

    // Glitch on bit 3 for 2 cycles between ticks.
    chg_seen = 0;
    snap = db_out;
    step(16'h0009, 1'b1);
    step(16'h0009, 1'b1);
    step(16'h0001, 1'b1);
    step(16'h0001, 1'b1);
    run_tick(16'h0001);
    run_tick(16'h0001);
    chk("glitch_db_out", db_out, snap);
    chk("glitch_no_change", 16'(chg_seen), 16'd0);

    // Multi-bit rise then fall.
    run_tick(16'h0000); run_tick(16'h0000); run_tick(16'h0000);
    chk("multi_start", db_out, 16'h0000);
    chg_seen = 0;
    run_tick(16'hA5A5); run_tick(16'hA5A5);
    chk("multi_hold", db_out, 16'h0000);
    run_tick(16'hA5A5);
    chk("multi_db_out", db_out, 16'hA5A5);
    chk("multi_change", {15'b0, db_change}, 16'h0001);
    chk("multi_one_pulse", 16'(chg_seen), 16'd1);
`ifdef DEBOUNCE_EDGE_EN
    chk("multi_rise", rise_pulse, 16'hA5A5);
`endif
    run_tick(16'h0000); run_tick(16'h0000); run_tick(16'h0000);
    chk("multi_fall_db", db_out, 16'h0000);
`ifdef DEBOUNCE_EDGE_EN
    chk("multi_fall", fall_pulse, 16'hA5A5);
`endif

    // Reset after two mismatching ticks; a full three ticks needed afterwards.
    run_tick(16'h8000); run_tick(16'h8000);
    step(16'h8000, 1'b0);
    chk("rstmid_db_out", db_out, 16'h0000);
    chk("rstmid_change", {15'b0, db_change}, 16'h0000);
    for (int k = 0; k < 12; k++) begin
      step(16'h8000, 1'b1);
      if (k == 10) chk("rstmid_before", db_out, 16'h0000);
      if (k == 11) chk("rstmid_after", db_out, 16'h8000);
    end

    // Randomized traffic with occasional resets, checked by the model in step().
    r = raw_in;
    for (int c = 0; c < 3000; c++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 3) r = 16'($urandom);
      else if (k < 20) r = r ^ 16'(1 << $urandom_range(0, 15));
      rn = ($urandom_range(0, 499) != 0);
      step(r, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
